// File: rtl/req_priority_arbiter_if.sv
// req_priority_arbiter_if
//   Request/grant bundle between N requesters and the arbiter.
//   req       : request vector, driven by the requester side (master)
//   gnt       : one-hot registered grant, driven by the arbiter (slave)
//   gnt_id    : binary index of the granted requester, 0 when idle
//   gnt_valid : high while any grant is active
interface req_priority_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid
  );
endinterface

// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter
//   Shares one downstream resource between N requesters. The owner keeps the
//   grant while it requests; a hold timer forces hand-over after MAX_HOLD
//   consecutive cycles when other requesters are waiting (MAX_HOLD=0 turns
//   preemption off).
//   Default search: highest requesting index wins.
//   ARB_RR_EN defined: descending circular search starting just below the
//   most recently granted index.
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous reset, active-high
//     bus : req_priority_arbiter_if.slave (req in; gnt, gnt_id, gnt_valid out)
//
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | no grant outstanding, outputs zero
//   GRANT | one requester owns the resource, hold timer runs
module req_priority_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  req_priority_arbiter_if.slave  bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  // With preemption disabled the counter is parked at 0.
  localparam logic [CW-1:0] HOLD_ONE = (MAX_HOLD > 0) ? CW'(1) : '0;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
`ifdef ARB_RR_EN
  logic [IDW-1:0] last_q, last_d;
`endif

  logic [N-1:0]   mask;
  logic [N-1:0]   cand;
  logic           do_arb;
  logic           timeout;
  logic [IDW-1:0] win;
  int             start;

  // Descending circular search beginning at index 'first'. Fixed priority is
  // the special case first = N-1.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input int first);
    logic [IDW-1:0] w;
    logic           found;
    w     = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (first + N - j) % N;
      if (!found && c[idx]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
`ifdef ARB_RR_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef ARB_RR_EN
    last_d      = last_q;
    start       = (int'(last_q) + N - 1) % N;
`else
    start       = N - 1;
`endif
    mask    = '0;
    do_arb  = 1'b0;
    timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);

    case (state_q)
      IDLE: begin
        if (|bus.req) do_arb = 1'b1;
      end
      GRANT: begin
        if (~|(bus.req & gnt_q)) begin
          do_arb = 1'b1;
        end else if (timeout && |(bus.req & ~gnt_q)) begin
          do_arb = 1'b1;
          mask   = gnt_q;
        end else if (timeout) begin
          hold_cnt_d = HOLD_ONE;
        end else if (hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    cand = bus.req & ~mask;
    win  = pick(cand, start);

    if (do_arb) begin
      if (|cand) begin
        state_d     = GRANT;
        gnt_d       = N'(1) << win;
        gnt_id_d    = win;
        gnt_valid_d = 1'b1;
        hold_cnt_d  = HOLD_ONE;
`ifdef ARB_RR_EN
        last_d      = win;
`endif
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    end
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.gnt_id    = gnt_id_q;
    bus.gnt_valid = gnt_valid_q;
  end
endmodule
